// File: rtl/ssriscv_pkg.sv
// Shared ssriscv types and constants for the write-back path.
// Consumers may be built with SSRISCV_WB_BYPASS_EN to add result forwarding.
package ssriscv_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned NREG       = 32;
   localparam int unsigned REG_ADDR_W = $clog2(NREG);

   // One producer result headed for the register file
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   // Which producer owns the write port this cycle (debug tracing)
   typedef enum logic [1:0] {
      WB_SRC_NONE = 2'd0,
      WB_SRC_ALU  = 2'd1,
      WB_SRC_LD   = 2'd2
   } wb_src_t;

endpackage

// File: rtl/ssriscv_scoreboard.sv
// Pending-write scoreboard: busy vector, WAW issue stall and RAW source lookups.
// SSRISCV_WB_BYPASS_EN adds forward-enable outputs that mask the source busy flags.
module ssriscv_scoreboard #(
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_rd,
   input  logic [AW-1:0] rs1,
   input  logic [AW-1:0] rs2,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_rd,
`ifdef SSRISCV_WB_BYPASS_EN
   output logic          rs1_fwd_en,
   output logic          rs2_fwd_en,
`endif
   output logic          iss_stall,
   output logic          rs1_busy,
   output logic          rs2_busy
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;
   logic            set_en;

   // A write retiring this cycle frees the register for a new issue
   assign iss_stall = busy[iss_rd] & ~(clr_en & (clr_rd == iss_rd));
   assign set_en    = iss_valid & ~iss_stall & (iss_rd != '0);

   // Clear first so that a same-cycle set wins
   always_comb begin
      busy_next = busy;
      if (clr_en) begin
         busy_next[clr_rd] = 1'b0;
      end
      if (set_en) begin
         busy_next[iss_rd] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

`ifdef SSRISCV_WB_BYPASS_EN
   assign rs1_fwd_en = clr_en & (clr_rd == rs1) & (rs1 != '0);
   assign rs2_fwd_en = clr_en & (clr_rd == rs2) & (rs2 != '0);
   assign rs1_busy   = busy[rs1] & ~rs1_fwd_en;
   assign rs2_busy   = busy[rs2] & ~rs2_fwd_en;
`else
   // The regfile read in the writing cycle still returns the old value
   assign rs1_busy = busy[rs1];
   assign rs2_busy = busy[rs2];
`endif

endmodule

// File: rtl/ssriscv_wb_arbiter.sv
// Register-file write-port arbiter: load-first fixed priority, one-cycle registered write.
// SSRISCV_WB_BYPASS_EN adds rsN_fwd_en/rsN_fwd_data forwarding ports.
module ssriscv_wb_arbiter
   import ssriscv_pkg::*;
#(
   parameter int unsigned XLEN = ssriscv_pkg::XLEN,
   parameter int unsigned NREG = ssriscv_pkg::NREG
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     iss_valid,
   input  logic [$clog2(NREG)-1:0]  iss_rd,
   output logic                     iss_stall,
   input  logic [$clog2(NREG)-1:0]  rs1,
   input  logic [$clog2(NREG)-1:0]  rs2,
   output logic                     rs1_busy,
   output logic                     rs2_busy,
`ifdef SSRISCV_WB_BYPASS_EN
   output logic                     rs1_fwd_en,
   output logic                     rs2_fwd_en,
   output logic [XLEN-1:0]          rs1_fwd_data,
   output logic [XLEN-1:0]          rs2_fwd_data,
`endif
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [$clog2(NREG)-1:0]  alu_rd,
   input  logic [XLEN-1:0]          alu_data,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [$clog2(NREG)-1:0]  ld_rd,
   input  logic [XLEN-1:0]          ld_data,
   output logic                     reg_write,
   output logic [$clog2(NREG)-1:0]  rd,
   output logic [XLEN-1:0]          reg_write_data
);

   localparam int unsigned AW = $clog2(NREG);

   wb_src_t sel_src;
   wb_req_t sel_req;
   logic    wr_next;

   // Loads cannot be back-pressured, so the ALU waits whenever a load is present
   assign ld_ready  = 1'b1;
   assign alu_ready = ~ld_valid;

   always_comb begin
      sel_src = WB_SRC_NONE;
      sel_req = '0;
      if (ld_valid) begin
         sel_src      = WB_SRC_LD;
         sel_req.rd   = ld_rd;
         sel_req.data = ld_data;
      end else if (alu_valid) begin
         sel_src      = WB_SRC_ALU;
         sel_req.rd   = alu_rd;
         sel_req.data = alu_data;
      end
   end

   // x0 results are accepted but never reach the regfile
   assign wr_next = (sel_src != WB_SRC_NONE) && (sel_req.rd != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write      <= 1'b0;
         rd             <= '0;
         reg_write_data <= '0;
      end else begin
         reg_write <= wr_next;
         if (wr_next) begin
            rd             <= sel_req.rd;
            reg_write_data <= sel_req.data;
         end
      end
   end

   ssriscv_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .iss_valid  (iss_valid),
      .iss_rd     (iss_rd),
      .rs1        (rs1),
      .rs2        (rs2),
      .clr_en     (reg_write),
      .clr_rd     (rd),
`ifdef SSRISCV_WB_BYPASS_EN
      .rs1_fwd_en (rs1_fwd_en),
      .rs2_fwd_en (rs2_fwd_en),
`endif
      .iss_stall  (iss_stall),
      .rs1_busy   (rs1_busy),
      .rs2_busy   (rs2_busy)
   );

`ifdef SSRISCV_WB_BYPASS_EN
   assign rs1_fwd_data = reg_write_data;
   assign rs2_fwd_data = reg_write_data;
`endif

endmodule

// File: tb/tb_ssriscv_wb_arbiter.sv
// Directed bench for ssriscv_wb_arbiter; follows SSRISCV_WB_BYPASS_EN when defined.
module tb_ssriscv_wb_arbiter;

`ifdef SSRISCV_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_stall;
   logic [4:0]  rs1, rs2;
   logic        rs1_busy, rs2_busy;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid, ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        reg_write;
   logic [4:0]  rd;
   logic [31:0] reg_write_data;
`ifdef SSRISCV_WB_BYPASS_EN
   logic        rs1_fwd_en, rs2_fwd_en;
   logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   ssriscv_wb_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .iss_valid      (iss_valid),
      .iss_rd         (iss_rd),
      .iss_stall      (iss_stall),
      .rs1            (rs1),
      .rs2            (rs2),
      .rs1_busy       (rs1_busy),
      .rs2_busy       (rs2_busy),
`ifdef SSRISCV_WB_BYPASS_EN
      .rs1_fwd_en     (rs1_fwd_en),
      .rs2_fwd_en     (rs2_fwd_en),
      .rs1_fwd_data   (rs1_fwd_data),
      .rs2_fwd_data   (rs2_fwd_data),
`endif
      .alu_valid      (alu_valid),
      .alu_ready      (alu_ready),
      .alu_rd         (alu_rd),
      .alu_data       (alu_data),
      .ld_valid       (ld_valid),
      .ld_ready       (ld_ready),
      .ld_rd          (ld_rd),
      .ld_data        (ld_data),
      .reg_write      (reg_write),
      .rd             (rd),
      .reg_write_data (reg_write_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] r);
      iss_valid = 1'b1;
      iss_rd    = r;
      tick();
      iss_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
      #2;
      check("rst_reg_write", 32'(reg_write), 32'd0);
      check("rst_rd", 32'(rd), 32'd0);
      check("rst_data", reg_write_data, 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd1);
      check("rst_alu_ready", 32'(alu_ready), 32'd1);
      tick(); tick();
      #3 rst_n = 1'b1;
      tick();

      // Simultaneous producers: load wins, ALU waits one cycle
      issue(5'd3);
      issue(5'd4);
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA;
      ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'hBBBB;
      #1;
      check("sim_alu_ready_c0", 32'(alu_ready), 32'd0);
      check("sim_ld_ready_c0", 32'(ld_ready), 32'd1);
      check("sim_reg_write_c0", 32'(reg_write), 32'd0);
      tick();
      ld_valid = 1'b0; rs1 = 5'd4;
      #1;
      check("sim_reg_write_c1", 32'(reg_write), 32'd1);
      check("sim_rd_c1", 32'(rd), 32'd4);
      check("sim_data_c1", reg_write_data, 32'hBBBB);
      check("sim_alu_ready_c1", 32'(alu_ready), 32'd1);
      check("sim_rs1_busy_c1", 32'(rs1_busy), BYP ? 32'd0 : 32'd1);
`ifdef SSRISCV_WB_BYPASS_EN
      check("sim_fwd_data_c1", rs1_fwd_data, 32'hBBBB);
`endif
      tick();
      alu_valid = 1'b0;
      #1;
      check("sim_reg_write_c2", 32'(reg_write), 32'd1);
      check("sim_rd_c2", 32'(rd), 32'd3);
      check("sim_data_c2", reg_write_data, 32'hAAAA);
      check("sim_rs1_busy_c2", 32'(rs1_busy), 32'd0);
      tick();
      rs2 = 5'd3;
      #1;
      check("sim_reg_write_c3", 32'(reg_write), 32'd0);
      check("sim_rd_hold_c3", 32'(rd), 32'd3);
      check("sim_data_hold_c3", reg_write_data, 32'hAAAA);
      check("sim_rs2_busy_c3", 32'(rs2_busy), 32'd0);

      // RAW: issue rd=7 in cycle 0, ALU returns it in cycle 2
      tick();
      iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
      #1;
      check("raw_rs1_busy_c0", 32'(rs1_busy), 32'd0);
      tick();
      iss_valid = 1'b0;
      #1;
      check("raw_rs1_busy_c1", 32'(rs1_busy), 32'd1);
      tick();
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
      #1;
      check("raw_rs1_busy_c2", 32'(rs1_busy), 32'd1);
      tick();
      alu_valid = 1'b0;
      #1;
      check("raw_reg_write_c3", 32'(reg_write), 32'd1);
      check("raw_rs1_busy_c3", 32'(rs1_busy), BYP ? 32'd0 : 32'd1);
`ifdef SSRISCV_WB_BYPASS_EN
      check("raw_fwd_en_c3", 32'(rs1_fwd_en), 32'd1);
      check("raw_fwd_data_c3", rs1_fwd_data, 32'h77);
`endif
      tick();
      #1;
      check("raw_rs1_busy_c4", 32'(rs1_busy), 32'd0);
      check("raw_reg_write_c4", 32'(reg_write), 32'd0);

      // WAW: stall while busy, released by the retiring write, set wins
      issue(5'd9);
      iss_valid = 1'b1; iss_rd = 5'd9;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      #1;
      check("waw_stall_busy", 32'(iss_stall), 32'd1);
      tick();
      alu_valid = 1'b0;
      #1;
      check("waw_reg_write", 32'(reg_write), 32'd1);
      check("waw_stall_on_write", 32'(iss_stall), 32'd0);
      tick();
      iss_valid = 1'b0; rs2 = 5'd9;
      #1;
      check("waw_set_wins_busy", 32'(rs2_busy), 32'd1);
      check("waw_set_wins_stall", 32'(iss_stall), 32'd1);
      alu_valid = 1'b1; alu_data = 32'h9A;
      tick();
      alu_valid = 1'b0;
      tick();
      #1;
      check("waw_cleared", 32'(rs2_busy), 32'd0);

      // x0 result and x0 issue
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
      iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
      #1;
      check("x0_alu_ready", 32'(alu_ready), 32'd1);
      check("x0_iss_stall", 32'(iss_stall), 32'd0);
      tick();
      alu_valid = 1'b0; iss_valid = 1'b0;
      #1;
      check("x0_reg_write", 32'(reg_write), 32'd0);
      check("x0_rs1_busy", 32'(rs1_busy), 32'd0);
      check("x0_iss_stall_after", 32'(iss_stall), 32'd0);

      // Back-to-back: rd=1..8 written on consecutive cycles
      for (int i = 1; i <= 8; i++) issue(5'(i));
      for (int k = 0; k <= 8; k++) begin
         alu_valid = (k < 8);
         alu_rd    = 5'(k + 1);
         alu_data  = 32'h100 + 32'(k + 1);
         rs1       = 5'(k + 1);
         rs2       = 5'(k);
         #1;
         if (k > 0) begin
            check($sformatf("b2b_reg_write_%0d", k), 32'(reg_write), 32'd1);
            check($sformatf("b2b_rd_%0d", k), 32'(rd), 32'(k));
            check($sformatf("b2b_data_%0d", k), reg_write_data, 32'h100 + 32'(k));
         end
         check($sformatf("b2b_rs1_busy_%0d", k), 32'(rs1_busy), (k < 8) ? 32'd1 : 32'd0);
         check($sformatf("b2b_rs2_busy_%0d", k), 32'(rs2_busy),
               (k == 0 || BYP) ? 32'd0 : 32'd1);
         tick();
      end
      alu_valid = 1'b0; rs2 = 5'd8;
      #1;
      check("b2b_done_reg_write", 32'(reg_write), 32'd0);
      check("b2b_done_rs2_busy", 32'(rs2_busy), 32'd0);

      // Reset during the write cycle drops the write
      tick();
      issue(5'd5);
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
      tick();
      alu_valid = 1'b0; rs1 = 5'd5;
      #1;
      check("rstmid_reg_write_pre", 32'(reg_write), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rstmid_reg_write", 32'(reg_write), 32'd0);
      check("rstmid_rd", 32'(rd), 32'd0);
      check("rstmid_data", reg_write_data, 32'd0);
      check("rstmid_rs1_busy", 32'(rs1_busy), 32'd0);
      tick();
      #3 rst_n = 1'b1;
      tick();
      #1;
      check("rstmid_after_reg_write", 32'(reg_write), 32'd0);
      check("rstmid_after_rs1_busy", 32'(rs1_busy), 32'd0);
      tick();
      #1;
      check("rstmid_after2_reg_write", 32'(reg_write), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
